mul_u32_pipe: RTL and testbench

//   Pipelined unsigned integer multiplier, 32x32 -> 64 bit, for the FPU mantissa datapath.

---
 rtl/mul_u32_pipe.sv | 75 +++++++
 tb/tb_mul_u32_pipe.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mul_u32_pipe.sv
// Two-stage pipelined unsigned multiplier for the FPU mantissa datapath.
// Stage 1 registers four half-width partial products; stage 2 sums them into the full product.
module mul_u32_pipe #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] y
);

  localparam int HALF = WIDTH / 2;

  logic [WIDTH-1:0]   a_hi_ext, a_lo_ext, b_hi_ext, b_lo_ext;
  logic [WIDTH-1:0]   hh_d, hl_d, lh_d, ll_d;
  logic [WIDTH-1:0]   hh_q, hl_q, lh_q, ll_q;
  logic               v1_q;
  logic [WIDTH:0]     mid_sum;
  logic [2*WIDTH-1:0] hh_term, mid_term, ll_term, product_d;

  // Halves are zero-extended to WIDTH so each partial product is computed at its exact width.
  always_comb begin
    a_hi_ext = {{HALF{1'b0}}, a[WIDTH-1:HALF]};
    a_lo_ext = {{HALF{1'b0}}, a[HALF-1:0]};
    b_hi_ext = {{HALF{1'b0}}, b[WIDTH-1:HALF]};
    b_lo_ext = {{HALF{1'b0}}, b[HALF-1:0]};
    hh_d     = a_hi_ext * b_hi_ext;
    hl_d     = a_hi_ext * b_lo_ext;
    lh_d     = a_lo_ext * b_hi_ext;
    ll_d     = a_lo_ext * b_lo_ext;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      hh_q <= '0;
      hl_q <= '0;
      lh_q <= '0;
      ll_q <= '0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        hh_q <= hh_d;
        hl_q <= hl_d;
        lh_q <= lh_d;
        ll_q <= ll_d;
      end
    end
  end

  // The cross-term sum keeps its carry bit, which lands at bit WIDTH+HALF of the product.
  always_comb begin
    mid_sum   = {1'b0, hl_q} + {1'b0, lh_q};
    hh_term   = {hh_q, {WIDTH{1'b0}}};
    mid_term  = {{(HALF-1){1'b0}}, mid_sum, {HALF{1'b0}}};
    ll_term   = {{WIDTH{1'b0}}, ll_q};
    product_d = hh_term + mid_term + ll_term;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
    end else begin
      out_valid <= v1_q;
      if (v1_q) begin
        y <= product_d;
      end
    end
  end

endmodule

// File: tb/tb_mul_u32_pipe.sv
// Self-checking bench for mul_u32_pipe: vector table, scoreboard queue, reset-flush corner cases.
module tb_mul_u32_pipe;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] y;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic [63:0] y;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] held_y = '0;
  logic        model_v1 = 1'b0;
  logic        model_v2 = 1'b0;
  logic        mon_en = 1'b0;
  vec_t        vecs[6];

  mul_u32_pipe #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .y        (y)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] ta, input logic [31:0] tb_v, input logic tv,
                                input logic [63:0] texp);
    @(negedge clk);
    a        = ta;
    b        = tb_v;
    in_valid = tv;
    if (tv && rst_n) exp_q.push_back(texp);
  endtask

  // Reference valid pipeline; a reset edge discards every queued expectation.
  always @(posedge clk) begin
    if (!rst_n) begin
      model_v2 = 1'b0;
      model_v1 = 1'b0;
      exp_q.delete();
      held_y   = '0;
    end else begin
      model_v2 = model_v1;
      model_v1 = in_valid;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check_output("out_valid", {63'b0, out_valid}, {63'b0, model_v2});
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got y=0x%h, expected no output at %0t", y, $time);
        end else begin
          held_y = exp_q.pop_front();
          check_output("y", y, held_y);
        end
      end else begin
        check_output("y_hold", y, held_y);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 500000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0] = '{32'd1234,       32'd1234,       64'd1522756};
    vecs[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE_00000001};
    vecs[2] = '{32'h12345678,   32'h0,          64'h0};
    vecs[3] = '{32'h0,          32'hFFFFFFFF,   64'h0};
    vecs[4] = '{32'h80000000,   32'h00000002,   64'h00000001_00000000};
    vecs[5] = '{32'h0000FFFF,   32'hFFFF0000,   64'h0000FFFE_00010000};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset_out_valid", {63'b0, out_valid}, 64'd0);
    check_output("reset_y", y, 64'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    $display("[TB] single pair latency");
    apply_stimulus(32'd1234, 32'd1234, 1'b1, 64'd1522756);
    apply_stimulus(32'd0, 32'd0, 1'b0, 64'd0);
    check_output("lat_edge1_valid", {63'b0, out_valid}, 64'd0);
    apply_stimulus(32'd0, 32'd0, 1'b0, 64'd0);
    check_output("lat_edge2_valid", {63'b0, out_valid}, 64'd1);
    check_output("lat_edge2_y", y, 64'd1522756);
    apply_stimulus(32'd0, 32'd0, 1'b0, 64'd0);
    check_output("lat_edge3_valid", {63'b0, out_valid}, 64'd0);
    check_output("lat_edge3_y", y, 64'd1522756);

    $display("[TB] vector table back-to-back");
    for (int i = 0; i < 6; i++) apply_stimulus(vecs[i].a, vecs[i].b, 1'b1, vecs[i].y);
    repeat (3) apply_stimulus(32'd0, 32'd0, 1'b0, 64'd0);

    $display("[TB] random stream with bubbles");
    for (int n = 0; n < 1000; ) begin
      logic [31:0] ra, rb;
      logic        rv;
      ra = 32'($urandom_range(0, 9999));
      rb = 32'($urandom_range(0, 9999));
      rv = ($urandom_range(0, 3) != 0);
      apply_stimulus(ra, rb, rv, 64'(ra) * 64'(rb));
      if (rv) n++;
    end
    repeat (3) apply_stimulus(32'd0, 32'd0, 1'b0, 64'd0);

    $display("[TB] reset with pairs in flight");
    apply_stimulus(32'd3, 32'd5, 1'b1, 64'd15);
    apply_stimulus(32'd1000, 32'd1000, 1'b1, 64'd1000000);
    @(negedge clk);
    rst_n    = 1'b0;
    a        = 32'd77;
    b        = 32'd99;
    in_valid = 1'b1;
    @(negedge clk);
    check_output("flush_out_valid", {63'b0, out_valid}, 64'd0);
    check_output("flush_y", y, 64'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    repeat (4) apply_stimulus(32'd0, 32'd0, 1'b0, 64'd0);
    apply_stimulus(32'd7, 32'd6, 1'b1, 64'd42);
    repeat (3) apply_stimulus(32'd0, 32'd0, 1'b0, 64'd0);

    check_output("queue_empty", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
